// File: rtl/forward_hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// forward_hazard_unit_pkg
//   Shared encodings for the forwarding/hazard unit:
//     - forward-select codes driven on fwd_cntl (one 2-bit field per source)
//     - state encoding of the multi-cycle (M-extension) tracking FSM
//   Code 2'b11 of the forward select is reserved and never produced.
// ----------------------------------------------------------------------------
package forward_hazard_unit_pkg;

  typedef enum logic [1:0] {
    FORWARD_ORG = 2'b00,  // operand comes from the ID/EX register (no bypass)
    FORWARD_MEM = 2'b01,  // bypass from the EX/MEM result
    FORWARD_WB  = 2'b10   // bypass from the MEM/WB result
  } fwd_sel_e;

  typedef enum logic {
    DIV_IDLE = 1'b0,      // no multi-cycle op outstanding
    DIV_BUSY = 1'b1       // a multi-cycle op is in flight, pend_rd valid
  } div_state_e;

endpackage : forward_hazard_unit_pkg

// File: rtl/forward_hazard_unit_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   W-bit up counter that sticks at all-ones. A synchronous clear has
//   priority over the increment; the asynchronous active-low reset zeroes it.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   inc    in   1  count one event this cycle
//   clr    in   1  zero the counter at the next edge (wins over inc)
//   cnt    out  W  current count
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/forward_hazard_unit.sv
// ----------------------------------------------------------------------------
// forward_hazard_unit
//   Pipeline operand-forwarding selector and stall generator.
//     - fwd_cntl: per EX source, selects MEM or WB bypass (MEM is younger and
//       wins) or the original operand. Register x0 is never forwarded.
//     - load-use hazard: ID instruction reads the destination of a load
//       currently in EX.
//     - multi-cycle hazard: while a mul/div op is outstanding, ID may not
//       issue another mul/div op, read its destination, or overwrite it (WAW).
//       The hazard stays up during the completion cycle and drops after it.
//     - saturating counters of load-use and multi-cycle stall cycles.
//
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   rs_ex      [NUM_SRC*AW]    EX source addresses, source i at [i*AW +: AW]
//   rd_mem, rd_wb [AW]         MEM / WB destinations
//   reg_file_wr_mem/_wb        MEM / WB write enables
//   valid_id                   ID holds a real instruction
//   rs_id      [NUM_SRC*AW]    ID source addresses (same packing)
//   rs_used_id [NUM_SRC]       ID source i is actually read
//   rd_id [AW], reg_file_wr_id ID destination and its write enable
//   muldiv_id                  ID instruction is a multi-cycle op
//   rd_ex [AW], mem_read_ex    EX destination, EX is a load
//   div_start, div_rd [AW]     multi-cycle unit accepts an op writing div_rd
//   div_done                   multi-cycle unit writes its result this cycle
//   perf_clr                   synchronous clear of both counters
//   fwd_cntl   [2*NUM_SRC]     forward select, source i at [2i +: 2]
//   stall, bubble_ex           hold PC/IF-ID, inject NOP into ID/EX
//   div_busy                   multi-cycle op outstanding
//   load_use_cnt, div_stall_cnt [CNT_W] stall-cycle counters
// ----------------------------------------------------------------------------
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC*AW-1:0] rs_ex,
  input  logic [AW-1:0]         rd_mem,
  input  logic [AW-1:0]         rd_wb,
  input  logic                  reg_file_wr_mem,
  input  logic                  reg_file_wr_wb,
  input  logic                  valid_id,
  input  logic [NUM_SRC*AW-1:0] rs_id,
  input  logic [NUM_SRC-1:0]    rs_used_id,
  input  logic [AW-1:0]         rd_id,
  input  logic                  reg_file_wr_id,
  input  logic                  muldiv_id,
  input  logic [AW-1:0]         rd_ex,
  input  logic                  mem_read_ex,
  input  logic                  div_start,
  input  logic [AW-1:0]         div_rd,
  input  logic                  div_done,
  input  logic                  perf_clr,
  output logic [2*NUM_SRC-1:0]  fwd_cntl,
  output logic                  stall,
  output logic                  bubble_ex,
  output logic                  div_busy,
  output logic [CNT_W-1:0]      load_use_cnt,
  output logic [CNT_W-1:0]      div_stall_cnt
);

  // --------------------------------------------------------------------------
  // Forwarding select
  // --------------------------------------------------------------------------
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  assign mem_fwd_ok = reg_file_wr_mem && (rd_mem != '0);
  assign wb_fwd_ok  = reg_file_wr_wb  && (rd_wb  != '0);

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fwd_cntl = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mem_fwd_ok && (rs_ex[i*AW +: AW] == rd_mem)) begin
        fwd_cntl[2*i +: 2] = FORWARD_MEM;
      end else if (wb_fwd_ok && (rs_ex[i*AW +: AW] == rd_wb)) begin
        fwd_cntl[2*i +: 2] = FORWARD_WB;
      end else begin
        fwd_cntl[2*i +: 2] = FORWARD_ORG;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load-use hazard
  // --------------------------------------------------------------------------
  logic rd_ex_match;
  logic load_use;

  always_comb begin
    rd_ex_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used_id[i] && (rs_id[i*AW +: AW] == rd_ex)) begin
        rd_ex_match = 1'b1;
      end
    end
  end

  assign load_use = valid_id && mem_read_ex && (rd_ex != '0) && rd_ex_match;

  // --------------------------------------------------------------------------
  // Multi-cycle op tracking FSM
  // --------------------------------------------------------------------------
  div_state_e    state_q,   state_d;
  logic [AW-1:0] pend_rd_q, pend_rd_d;

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    unique case (state_q)
      DIV_IDLE: begin
        // A completion with nothing outstanding is ignored; a start always
        // opens a new pending op.
        if (div_start) begin
          state_d   = DIV_BUSY;
          pend_rd_d = div_rd;
        end
      end
      DIV_BUSY: begin
        // A start without a completion cannot be accepted by the unit, so it
        // leaves the tracked destination alone. Completion plus start is a
        // back-to-back hand-over to the new op.
        if (div_done) begin
          if (div_start) begin
            pend_rd_d = div_rd;
          end else begin
            state_d = DIV_IDLE;
          end
        end
      end
      default: begin
        state_d   = DIV_IDLE;
        pend_rd_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      pend_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Multi-cycle hazard: evaluated from the registered state, so it is still
  // set in the div_done cycle and drops the cycle after.
  // --------------------------------------------------------------------------
  logic pend_src_match;
  logic pend_waw;
  logic div_hazard;

  always_comb begin
    pend_src_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used_id[i] && (rs_id[i*AW +: AW] == pend_rd_q)) begin
        pend_src_match = 1'b1;
      end
    end
  end

  assign pend_waw   = reg_file_wr_id && (rd_id == pend_rd_q);
  assign div_hazard = (state_q == DIV_BUSY) && valid_id &&
                      (muldiv_id ||
                       ((pend_rd_q != '0) && (pend_src_match || pend_waw)));

  assign stall     = load_use || div_hazard;
  assign bubble_ex = stall;
  assign div_busy  = (state_q == DIV_BUSY);

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_load_use_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (load_use),
    .clr   (perf_clr),
    .cnt   (load_use_cnt)
  );

  sat_counter #(.W(CNT_W)) u_div_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (div_hazard),
    .clr   (perf_clr),
    .cnt   (div_stall_cnt)
  );

endmodule : forward_hazard_unit

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2 (legal 1..4), number of source operands per instruction.
REQ-002 The block SHALL have parameter AW, default 5, register-address width.
REQ-003 The block SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 The block SHALL have a single clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_ex  in  NUM_SRC*AW  EX-stage source addresses, source i at [i*AW +: AW]
- rd_mem, rd_wb  in  AW  MEM/WB destination addresses
- reg_file_wr_mem, reg_file_wr_wb  in  1  MEM/WB write enables
- valid_id  in  1  ID stage holds a real instruction
- rs_id  in  NUM_SRC*AW  ID-stage source addresses, same packing
- rs_used_id  in  NUM_SRC  source i actually read by ID instruction
- rd_id  in  AW  ID-stage destination
- reg_file_wr_id  in  1  ID instruction writes rd_id
- muldiv_id  in  1  ID instruction is a multi-cycle M-extension op
- rd_ex  in  AW  EX-stage destination
- mem_read_ex  in  1  EX instruction is a load
- div_start  in  1  multi-cycle unit accepts an op this cycle
- div_rd  in  AW  destination of that op
- div_done  in  1  multi-cycle unit writes its result this cycle
- perf_clr  in  1  synchronous clear of counters
- fwd_cntl  out  2*NUM_SRC  per-source forward select, source i at [2i +: 2]
- stall  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX register
- div_busy  out  1  multi-cycle op pending
- load_use_cnt, div_stall_cnt  out  CNT_W  stall-cycle counters

Function
REQ-005 fwd_cntl[i] SHALL be combinational: FORWARD_MEM if rs_ex[i]==rd_mem, rd_mem!=0, reg_file_wr_mem; else FORWARD_WB under the same conditions on WB; else FORWARD_ORG; MEM wins over WB; code 2'b11 never driven.
REQ-006 load_use SHALL be true when valid_id, mem_read_ex, rd_ex!=0 and any i has rs_used_id[i] && rs_id[i]==rd_ex.
REQ-007 An FSM SHALL have states DIV_IDLE and DIV_BUSY plus register pend_rd.
REQ-008 DIV_IDLE: div_start -> DIV_BUSY, pend_rd<=div_rd; div_done alone ignored; div_start with div_done -> start wins.
REQ-009 DIV_BUSY: div_done without div_start -> DIV_IDLE; div_done with div_start -> stay DIV_BUSY, pend_rd<=div_rd; div_start without div_done ignored, pend_rd unchanged.
REQ-010 div_hazard SHALL be true in DIV_BUSY when valid_id and (muldiv_id, or pend_rd!=0 and (any used rs_id[i]==pend_rd, or reg_file_wr_id && rd_id==pend_rd)).
REQ-011 div_hazard SHALL remain asserted during the div_done cycle and clear the cycle after.
REQ-012 stall and bubble_ex SHALL both equal load_use || div_hazard, combinational, zero latency.
REQ-013 div_busy SHALL be 1 exactly when state is DIV_BUSY.
REQ-014 load_use_cnt SHALL increment once per cycle with load_use; div_stall_cnt once per cycle with div_hazard; both may increment in the same cycle.
REQ-015 Counters SHALL saturate at all-ones; perf_clr zeroes both next edge with priority over increment.

Reset
REQ-016 rst_n low SHALL immediately force DIV_IDLE, pend_rd=0, both counters 0, div_busy=0, including mid-operation (pending op discarded).
REQ-017 Combinational outputs SHALL reflect inputs during reset; stall SHALL be 0 unless load_use.

Structure
REQ-018 FORWARD_ORG=2'b00, FORWARD_MEM=2'b01, FORWARD_WB=2'b10 and DIV_IDLE/DIV_BUSY encodings SHALL live in shared defines.vh.
REQ-019 One sub-module sat_counter (parameter W, inputs inc/clr) SHALL be instantiated twice.

Verification
REQ-020 rs_ex={x3,x3}, rd_mem=3 wr, rd_wb=3 wr -> both fwd_cntl=01; rd_mem=0 -> 10; wr_wb=0 -> 00.
REQ-021 mem_read_ex, rd_ex=5, rs_id[1]=5 with rs_used_id=01 -> stall=0; rs_used_id=10 -> stall=bubble_ex=1, load_use_cnt +1.
REQ-022 div_start rd=7; ID reads x7 -> stall through div_done cycle, 0 next cycle; div_stall_cnt equals stalled cycles.
REQ-023 BUSY, div_done and div_start(rd=9) same cycle -> div_busy stays 1, ID reading x9 stalls, x7 no longer stalls.
REQ-024 CNT_W=4, 20 load-use cycles -> load_use_cnt=15; perf_clr with hazard -> 0.
REQ-025 rst_n low in DIV_BUSY -> div_busy=0 immediately, counters 0, no div stall after release.
